// File: rtl/typewriter_pkg.sv
// Shared constants, state encoding and cursor helpers for the typewriter buffer controller.
// Geometry, PS/2 scan codes and the key classes produced by scan_classify.
package typewriter_pkg;

  localparam int COLS  = 16;
  localparam int ROWS  = 4;
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_BRK,
    ST_EXT
  } state_t;

  typedef enum logic [2:0] {
    KEY_BREAK,
    KEY_EXT,
    KEY_ENTER,
    KEY_BKSP,
    KEY_ESC,
    KEY_OTHER
  } key_t;

  // First column of the following row; COLS is a power of two, so row 3 wraps to 0.
  function automatic logic [AW-1:0] next_row(input logic [AW-1:0] pos);
    logic [AW-1:0] last_col;
    last_col = pos | AW'(COLS - 1);
    return last_col + AW'(1);
  endfunction

endpackage

// File: rtl/typewriter_buffer_ctrl_if.sv
// Keyboard-side inputs and RAM-write-side outputs of the typewriter buffer controller.
// The controller takes the master view; the surrounding system takes the slave view.
interface typewriter_buffer_ctrl_if;
  import typewriter_pkg::*;

  logic          scan_done_tick;
  logic [7:0]    scan_data;
  logic [7:0]    ascii_data;
  logic          we;
  logic [AW-1:0] write_address;
  logic [7:0]    ram_in;
  logic [AW-1:0] cursor;
  logic          busy;

  modport master (
    input  scan_done_tick,
    input  scan_data,
    input  ascii_data,
    output we,
    output write_address,
    output ram_in,
    output cursor,
    output busy
  );

  modport slave (
    output scan_done_tick,
    output scan_data,
    output ascii_data,
    input  we,
    input  write_address,
    input  ram_in,
    input  cursor,
    input  busy
  );

endinterface

// File: rtl/scan_classify.sv
// Combinational decode of a PS/2 scan code byte into the key classes the controller acts on.
module scan_classify
  import typewriter_pkg::*;
(
  input  logic [7:0] i_scan_data,
  output key_t       o_key
);

  always_comb begin
    case (i_scan_data)
      SC_BREAK: o_key = KEY_BREAK;
      SC_EXT:   o_key = KEY_EXT;
      SC_ENTER: o_key = KEY_ENTER;
      SC_BKSP:  o_key = KEY_BKSP;
      SC_ESC:   o_key = KEY_ESC;
      default:  o_key = KEY_OTHER;
    endcase
  end

endmodule

// File: rtl/typewriter_buffer_ctrl.sv
// Sequences every write into the 64-entry LCD character buffer: the blanking sweep after
// reset / Esc, printable characters at the cursor, Backspace, Enter and PS/2 prefix handling.
module typewriter_buffer_ctrl
  import typewriter_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  typewriter_buffer_ctrl_if.master bus
);

  state_t        r_state,     w_state_nxt;
  logic [AW:0]   r_clr_cnt,   w_clr_cnt_nxt;
  logic [AW-1:0] r_cursor,    w_cursor_nxt;
  logic          r_we,        w_we_nxt;
  logic [AW-1:0] r_addr,      w_addr_nxt;
  logic [7:0]    r_data,      w_data_nxt;
  key_t          w_key;

  scan_classify u_classify (
    .i_scan_data (bus.scan_data),
    .o_key       (w_key)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_cursor  <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_cursor  <= w_cursor_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_cursor_nxt  = r_cursor;
    w_we_nxt      = 1'b0;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;

    case (r_state)
      ST_CLEAR: begin
        // The extra count bit marks "address 63 already issued"; that cycle leaves the sweep.
        if (!r_clr_cnt[AW]) begin
          w_we_nxt      = 1'b1;
          w_addr_nxt    = r_clr_cnt[AW-1:0];
          w_data_nxt    = BLANK;
          w_clr_cnt_nxt = r_clr_cnt + (AW+1)'(1);
        end else begin
          w_state_nxt  = ST_IDLE;
          w_cursor_nxt = '0;
        end
      end

      ST_IDLE: begin
        if (bus.scan_done_tick) begin
          case (w_key)
            KEY_BREAK: w_state_nxt = ST_BRK;
            KEY_EXT:   w_state_nxt = ST_EXT;
            KEY_ESC: begin
              // Address 0 is issued on the Esc edge itself, so the sweep resumes at 1.
              w_state_nxt   = ST_CLEAR;
              w_we_nxt      = 1'b1;
              w_addr_nxt    = '0;
              w_data_nxt    = BLANK;
              w_clr_cnt_nxt = (AW+1)'(1);
            end
            KEY_ENTER: w_cursor_nxt = next_row(r_cursor);
            KEY_BKSP: begin
              if (r_cursor != '0) begin
                w_cursor_nxt = r_cursor - AW'(1);
                w_we_nxt     = 1'b1;
                w_addr_nxt   = r_cursor - AW'(1);
                w_data_nxt   = BLANK;
              end
            end
            default: begin
              if (bus.ascii_data != 8'h00) begin
                w_we_nxt     = 1'b1;
                w_addr_nxt   = r_cursor;
                w_data_nxt   = bus.ascii_data;
                w_cursor_nxt = r_cursor + AW'(1);
              end
            end
          endcase
        end
      end

      ST_BRK: begin
        if (bus.scan_done_tick) w_state_nxt = ST_IDLE;
      end

      ST_EXT: begin
        if (bus.scan_done_tick) w_state_nxt = (w_key == KEY_BREAK) ? ST_BRK : ST_IDLE;
      end

      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  assign bus.we            = r_we;
  assign bus.write_address = r_addr;
  assign bus.ram_in        = r_data;
  assign bus.cursor        = r_cursor;
  assign bus.busy          = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_typewriter_buffer_ctrl.sv
// Directed and randomized checks of typewriter_buffer_ctrl against a keystroke-level model.
module tb_typewriter_buffer_ctrl;
  import typewriter_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   chk_en = 1'b0;

  typewriter_buffer_ctrl_if bus ();

  typewriter_buffer_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep position (-1 = none), prefix mode, cursor, last write.
  int  m_clear;
  int  m_mode;     // 0 normal, 1 after F0, 2 after E0
  int  m_cursor;
  bit  m_we;
  int  m_addr;
  int  m_data;
  byte unsigned m_screen [64];
  byte unsigned d_screen [64];

  task automatic m_write(input int a, input int d);
    m_we   = 1'b1;
    m_addr = a;
    m_data = d;
    m_screen[a] = d[7:0];
  endtask

  always @(posedge clk or posedge reset) begin
    logic [7:0] sc;
    if (reset) begin
      m_clear = 0; m_mode = 0; m_cursor = 0;
      m_we = 1'b0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 1'b0;
      sc   = bus.scan_data;
      if (m_clear >= 0) begin
        if (m_clear < 64) begin
          m_write(m_clear, 32);
          m_clear++;
        end else begin
          m_clear  = -1;
          m_cursor = 0;
        end
      end else if (bus.scan_done_tick) begin
        if (m_mode == 1) m_mode = 0;
        else if (m_mode == 2) m_mode = (sc == 8'hF0) ? 1 : 0;
        else if (sc == 8'hF0) m_mode = 1;
        else if (sc == 8'hE0) m_mode = 2;
        else if (sc == 8'h76) begin
          m_write(0, 32);
          m_clear = 1;
        end else if (sc == 8'h5A) m_cursor = ((m_cursor / 16 + 1) * 16) % 64;
        else if (sc == 8'h66) begin
          if (m_cursor != 0) begin
            m_cursor = m_cursor - 1;
            m_write(m_cursor, 32);
          end
        end else if (bus.ascii_data != 8'h00) begin
          m_write(m_cursor, int'(bus.ascii_data));
          m_cursor = (m_cursor + 1) % 64;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_we",   32'(bus.we),            32'(m_we));
      check("cmp_addr", 32'(bus.write_address), 32'(m_addr));
      check("cmp_data", 32'(bus.ram_in),        32'(m_data));
      check("cmp_cur",  32'(bus.cursor),        32'(m_cursor));
      check("cmp_busy", 32'(bus.busy),          32'(m_clear >= 0));
    end
    if (bus.we) d_screen[bus.write_address] = bus.ram_in;
  end

  task automatic tick(input logic [7:0] sc, input logic [7:0] asc);
    bus.scan_done_tick = 1'b1;
    bus.scan_data      = sc;
    bus.ascii_data     = asc;
    @(negedge clk);
    bus.scan_done_tick = 1'b0;
  endtask

  task automatic type_n(input int n);
    for (int i = 0; i < n; i++) tick(8'h1C, 8'(8'h61 + (i % 26)));
  endtask

  task automatic wait_not_busy(input string name, input int budget, output int cycles);
    cycles = 0;
    while (bus.busy && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (bus.busy) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int cnt;
    int r;
    bus.scan_done_tick = 1'b0;
    bus.scan_data      = 8'h00;
    bus.ascii_data     = 8'h00;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;                       // cycle 0 starts here

    @(negedge clk);
    check("rst_we",   32'(bus.we), 0);
    check("rst_busy", 32'(bus.busy), 1);
    check("rst_cur",  32'(bus.cursor), 0);
    check("rst_addr", 32'(bus.write_address), 0);
    check("rst_data", 32'(bus.ram_in), 0);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      check("sweep_we",   32'(bus.we), 1);
      check("sweep_addr", 32'(bus.write_address), 32'(k - 1));
      check("sweep_data", 32'(bus.ram_in), 32'h20);
      check("sweep_busy", 32'(bus.busy), 1);
    end
    @(negedge clk);                        // cycle 65
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_we",   32'(bus.we), 0);
    check("idle_cur",  32'(bus.cursor), 0);

    tick(8'h1C, 8'h61);
    check("a_we",   32'(bus.we), 1);
    check("a_addr", 32'(bus.write_address), 0);
    check("a_data", 32'(bus.ram_in), 32'h61);
    check("a_cur",  32'(bus.cursor), 1);
    tick(8'hF0, 8'h00);
    check("brk_we", 32'(bus.we), 0);
    tick(8'h1C, 8'h61);
    check("brk2_we",  32'(bus.we), 0);
    check("brk2_cur", 32'(bus.cursor), 1);

    type_n(4);
    check("pre_enter_cur", 32'(bus.cursor), 5);
    tick(8'h5A, 8'h0D);
    check("enter_we",  32'(bus.we), 0);
    check("enter_cur", 32'(bus.cursor), 16);
    type_n(34);
    check("pre_enter2_cur", 32'(bus.cursor), 50);
    tick(8'h5A, 8'h0D);
    check("enter_wrap_cur", 32'(bus.cursor), 0);

    type_n(3);
    tick(8'h66, 8'h08);
    check("bs_we",   32'(bus.we), 1);
    check("bs_addr", 32'(bus.write_address), 2);
    check("bs_data", 32'(bus.ram_in), 32'h20);
    check("bs_cur",  32'(bus.cursor), 2);
    tick(8'h66, 8'h08);
    tick(8'h66, 8'h08);
    tick(8'h66, 8'h08);
    check("bs0_we",  32'(bus.we), 0);
    check("bs0_cur", 32'(bus.cursor), 0);

    type_n(63);
    tick(8'h1A, 8'h5A);
    check("wrap_addr", 32'(bus.write_address), 63);
    check("wrap_data", 32'(bus.ram_in), 32'h5A);
    check("wrap_cur",  32'(bus.cursor), 0);

    tick(8'h76, 8'h1B);
    check("esc_busy", 32'(bus.busy), 1);
    check("esc_we",   32'(bus.we), 1);
    check("esc_addr", 32'(bus.write_address), 0);
    tick(8'h1C, 8'h61);                    // dropped during sweep
    check("drop_addr", 32'(bus.write_address), 1);
    check("drop_data", 32'(bus.ram_in), 32'h20);
    wait_not_busy("esc_sweep", 200, cnt);
    check("esc_len", 32'(cnt), 63);
    check("esc_cur", 32'(bus.cursor), 0);

    tick(8'hE0, 8'h00);
    tick(8'h75, 8'h38);
    check("ext_we", 32'(bus.we), 0);
    tick(8'hE0, 8'h00);
    tick(8'hF0, 8'h00);
    tick(8'h75, 8'h38);
    check("extbrk_we", 32'(bus.we), 0);
    tick(8'h1C, 8'h61);
    check("after_ext_we",   32'(bus.we), 1);
    check("after_ext_addr", 32'(bus.write_address), 0);
    check("after_ext_cur",  32'(bus.cursor), 1);

    tick(8'h76, 8'h1B);
    cnt = 0;
    while (!(bus.we && bus.write_address == 6'd30) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_30", 32'(bus.write_address), 30);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_we",   32'(bus.we), 0);
    check("mid_rst_addr", 32'(bus.write_address), 0);
    check("mid_rst_busy", 32'(bus.busy), 1);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("restart_we",   32'(bus.we), 1);
    check("restart_addr", 32'(bus.write_address), 0);
    wait_not_busy("restart_sweep", 200, cnt);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        bus.scan_done_tick = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end else begin
        r = int'($urandom_range(0, 99));
        bus.scan_done_tick = ($urandom_range(0, 1) == 1);
        bus.ascii_data     = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(33, 126));
        if (r < 8)       bus.scan_data = SC_BREAK;
        else if (r < 14) bus.scan_data = SC_EXT;
        else if (r < 22) bus.scan_data = SC_ENTER;
        else if (r < 32) bus.scan_data = SC_BKSP;
        else if (r < 33) bus.scan_data = SC_ESC;
        else             bus.scan_data = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
    end
    bus.scan_done_tick = 1'b0;
    @(negedge clk);
    wait_not_busy("final_sweep", 200, cnt);
    for (int a = 0; a < 64; a++) check("screen", 32'(d_screen[a]), 32'(m_screen[a]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
